// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone burst responder.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int WB_MEM_DEPTH  = 24;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLASSIC = 2'b01,
    ST_BURST   = 2'b10,
    ST_ERR     = 2'b11
  } wb_state_e;

  // Constant-address bursts are not served; they terminate with an error.
  function automatic logic cti_supported(input logic [2:0] cti);
    return (cti == CLASSIC) || (cti == INCR) || (cti == EOB);
  endfunction

endpackage

// File: rtl/wb_slave_mem.sv
// Word memory with a tag bit per word: byte-enable write, combinational read,
// asynchronous clear.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int SEL_WIDTH  = WB_SEL_WIDTH,
  parameter int MEM_DEPTH  = WB_MEM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [SEL_WIDTH-1:0]  wsel_i,
  input  logic                  wtag_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rtag_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  // Bit DATA_WIDTH of each word holds the tag.
  logic [DATA_WIDTH:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (wsel_i[k]) begin
          mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
      mem_q[waddr_i][DATA_WIDTH] <= wtag_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    rtag_o  = 1'b0;
    if ({1'b0, raddr_i} < DEPTH) begin
      rdata_o = mem_q[raddr_i][DATA_WIDTH-1:0];
      rtag_o  = mem_q[raddr_i][DATA_WIDTH];
    end
  end

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone B4 responder serving classic cycles and incrementing bursts from a
// tagged register memory; out-of-range or unsupported accesses end with err_o.
module wb_burst_slave
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = WB_MEM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  input  logic [2:0]            cti_i,
  input  logic                  tag_add_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  tag_o,
  output logic [ADDR_WIDTH-1:0] counter_out,
  output logic [1:0]            state_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  wb_state_e             state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rtag;

  wb_slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (acc_addr),
    .wdata_i (data_i),
    .wsel_i  (sel_i),
    .wtag_i  (tag_add_i),
    .raddr_i (acc_addr),
    .rdata_o (rdata),
    .rtag_o  (rtag)
  );

  // The beat is decided at the sampling edge, so the write commits on the same
  // edge that raises ack and a following beat reads the updated word.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    baddr_d   = baddr_q;
    counter_d = counter_q;
    acc_addr  = addr_i;
    if (!cyc_i) begin
      state_d   = ST_IDLE;
      counter_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            if (!in_range(addr_i) || !cti_supported(cti_i)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              ack_d = 1'b1;
              if (cti_i == INCR) begin
                state_d = ST_BURST;
                baddr_d = addr_i + ADDR_WIDTH'(1);
              end else begin
                state_d = ST_CLASSIC;
              end
            end
          end
        end
        ST_BURST: begin
          acc_addr = baddr_q;
          if (stb_i) begin
            if (!in_range(baddr_q)) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ack_d   = 1'b1;
              baddr_d = baddr_q + ADDR_WIDTH'(1);
              if (cti_i == EOB) begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (ack_d && (counter_q != '1)) begin
        counter_d = counter_q + ADDR_WIDTH'(1);
      end
    end
    mem_we = ack_d & we_i & (|sel_i);
    data_d = (ack_d & ~we_i) ? rdata : '0;
    tag_d  = ack_d & ~we_i & rtag;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      tag_q     <= 1'b0;
      counter_q <= '0;
      baddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      counter_q <= counter_d;
      baddr_q   <= baddr_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign data_o      = data_q;
  assign tag_o       = tag_q;
  assign counter_out = counter_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_wb_burst_slave.sv
// Directed bench for wb_burst_slave: a per-cycle vector table plus hand-written
// sequences for burst overrun, counter saturation and reset mid-burst.
module tb_wb_burst_slave;

   localparam logic       Y  = 1'b1;
   localparam logic       N  = 1'b0;
   localparam logic [2:0] CC = 3'b000;
   localparam logic [2:0] CK = 3'b001;
   localparam logic [2:0] CI = 3'b010;
   localparam logic [2:0] CE = 3'b111;
   localparam logic [1:0] SI = 2'b00;
   localparam logic [1:0] SC = 2'b01;
   localparam logic [1:0] SB = 2'b10;
   localparam logic [1:0] SE = 2'b11;

   logic        clock;
   logic        rstN;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        we;
   logic [3:0]  sel;
   logic        stb;
   logic        cyc;
   logic [2:0]  cti;
   logic        tagIn;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        tagOut;
   logic [4:0]  counter;
   logic [1:0]  state;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic        tag;
      logic        expAck;
      logic        expErr;
      logic [31:0] expData;
      logic        expTag;
      logic [4:0]  expCnt;
      logic [1:0]  expState;
      logic        chkData;
   } vec_t;

   vec_t vectors[$];

   wb_burst_slave #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32),
      .SEL_WIDTH  (4),
      .MEM_DEPTH  (24)
   ) dut (
      .clk_i       (clock),
      .rst_ni      (rstN),
      .addr_i      (addr),
      .data_i      (wdata),
      .we_i        (we),
      .sel_i       (sel),
      .stb_i       (stb),
      .cyc_i       (cyc),
      .cti_i       (cti),
      .tag_add_i   (tagIn),
      .ack_o       (ack),
      .err_o       (err),
      .data_o      (rdata),
      .tag_o       (tagOut),
      .counter_out (counter),
      .state_out   (state)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net so the run always ends even if a sequence goes astray.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addRow(input logic c, input logic s, input logic w,
                                  input logic [4:0] a, input logic [31:0] d,
                                  input logic [3:0] se, input logic [2:0] ct, input logic tg,
                                  input logic eAck, input logic eErr, input logic [31:0] eData,
                                  input logic eTag, input logic [4:0] eCnt,
                                  input logic [1:0] eState, input logic chk);
      vec_t v;
      v.cyc = c; v.stb = s; v.we = w; v.addr = a; v.data = d; v.sel = se;
      v.cti = ct; v.tag = tg; v.expAck = eAck; v.expErr = eErr; v.expData = eData;
      v.expTag = eTag; v.expCnt = eCnt; v.expState = eState; v.chkData = chk;
      vectors.push_back(v);
   endfunction

   task automatic drive(input logic c, input logic s, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] se, input logic [2:0] ct,
                        input logic tg);
      cyc = c; stb = s; we = w; addr = a; wdata = d; sel = se; cti = ct; tagIn = tg;
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.cyc, v.stb, v.we, v.addr, v.data, v.sel, v.cti, v.tag);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic checkRow(input int idx, input vec_t v);
      checkOutput($sformatf("row%0d.ack", idx), 32'(ack), 32'(v.expAck));
      checkOutput($sformatf("row%0d.err", idx), 32'(err), 32'(v.expErr));
      checkOutput($sformatf("row%0d.state", idx), 32'(state), 32'(v.expState));
      checkOutput($sformatf("row%0d.counter", idx), 32'(counter), 32'(v.expCnt));
      if (v.chkData) begin
         checkOutput($sformatf("row%0d.data", idx), rdata, v.expData);
         checkOutput($sformatf("row%0d.tag", idx), 32'(tagOut), 32'(v.expTag));
      end
   endtask

   // One classic read inside its own bus cycle, checked on the ack cycle.
   task automatic classicRead(input string name, input logic [4:0] a,
                              input logic [31:0] expData, input logic expTag);
      drive(Y, Y, N, a, 32'h0, 4'hF, CC, N);
      tick();
      checkOutput({name, ".ack"}, 32'(ack), 32'(1));
      checkOutput({name, ".data"}, rdata, expData);
      checkOutput({name, ".tag"}, 32'(tagOut), 32'(expTag));
      drive(Y, N, N, a, 32'h0, 4'hF, CC, N);
      tick();
      drive(N, N, N, 5'd0, 32'h0, 4'h0, CC, N);
      tick();
   endtask

   initial begin
      //    cyc stb we addr   data           sel   cti tag  ack err data           tag cnt    st  chk
      // classic write then read of addr 3
      addRow(Y, Y, Y, 5'd3,  32'hDEADBEEF, 4'hF, CC, Y,   Y, N, 32'h0,         N, 5'd1, SC, N);
      addRow(Y, N, N, 5'd3,  32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd1, SI, Y);
      addRow(Y, Y, N, 5'd3,  32'h0,        4'hF, CC, N,   Y, N, 32'hDEADBEEF,  Y, 5'd2, SC, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // byte-select merge on addr 5
      addRow(Y, Y, Y, 5'd5,  32'h11223344, 4'hF, CC, N,   Y, N, 32'h0,         N, 5'd1, SC, N);
      addRow(Y, N, N, 5'd5,  32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd1, SI, Y);
      addRow(Y, Y, Y, 5'd5,  32'hAABBCCDD, 4'h5, CC, N,   Y, N, 32'h0,         N, 5'd2, SC, N);
      addRow(Y, N, N, 5'd5,  32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd2, SI, Y);
      addRow(Y, Y, N, 5'd5,  32'h0,        4'hF, CC, N,   Y, N, 32'h11BB33DD,  N, 5'd3, SC, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // sel = 0 write is acked but changes neither data nor tag
      addRow(Y, Y, Y, 5'd5,  32'hFFFFFFFF, 4'h0, CC, Y,   Y, N, 32'h0,         N, 5'd1, SC, N);
      addRow(Y, N, N, 5'd5,  32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd1, SI, Y);
      addRow(Y, Y, N, 5'd5,  32'h0,        4'hF, CC, N,   Y, N, 32'h11BB33DD,  N, 5'd2, SC, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // out-of-range and unsupported cycle type
      addRow(Y, Y, N, 5'd30, 32'h0,        4'hF, CC, N,   N, Y, 32'h0,         N, 5'd0, SE, Y);
      addRow(Y, N, N, 5'd30, 32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      addRow(Y, Y, N, 5'd2,  32'h0,        4'hF, CK, N,   N, Y, 32'h0,         N, 5'd0, SE, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      addRow(Y, Y, N, 5'd23, 32'h0,        4'hF, CC, N,   Y, N, 32'h0,         N, 5'd1, SC, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      addRow(Y, Y, N, 5'd24, 32'h0,        4'hF, CC, N,   N, Y, 32'h0,         N, 5'd0, SE, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // end-of-burst type on a lone access is a classic cycle
      addRow(Y, Y, N, 5'd3,  32'h0,        4'hF, CE, N,   Y, N, 32'hDEADBEEF,  Y, 5'd1, SC, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // 4-beat incrementing write at 8, then read back
      addRow(Y, Y, Y, 5'd8,  32'd1,        4'hF, CI, N,   Y, N, 32'h0,         N, 5'd1, SB, N);
      addRow(Y, Y, Y, 5'd0,  32'd2,        4'hF, CI, N,   Y, N, 32'h0,         N, 5'd2, SB, N);
      addRow(Y, Y, Y, 5'd0,  32'd3,        4'hF, CI, N,   Y, N, 32'h0,         N, 5'd3, SB, N);
      addRow(Y, Y, Y, 5'd0,  32'd4,        4'hF, CE, N,   Y, N, 32'h0,         N, 5'd4, SI, N);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      addRow(Y, Y, N, 5'd8,  32'h0,        4'hF, CI, N,   Y, N, 32'd1,         N, 5'd1, SB, Y);
      addRow(Y, Y, N, 5'd0,  32'h0,        4'hF, CI, N,   Y, N, 32'd2,         N, 5'd2, SB, Y);
      addRow(Y, Y, N, 5'd0,  32'h0,        4'hF, CI, N,   Y, N, 32'd3,         N, 5'd3, SB, Y);
      addRow(Y, Y, N, 5'd0,  32'h0,        4'hF, CE, N,   Y, N, 32'd4,         N, 5'd4, SI, Y);
      addRow(Y, N, N, 5'd0,  32'h0,        4'hF, CC, N,   N, N, 32'h0,         N, 5'd4, SI, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);
      // burst read with a two-cycle wait state after beat 2
      addRow(Y, Y, N, 5'd8,  32'h0,        4'hF, CI, N,   Y, N, 32'd1,         N, 5'd1, SB, Y);
      addRow(Y, Y, N, 5'd0,  32'h0,        4'hF, CI, N,   Y, N, 32'd2,         N, 5'd2, SB, Y);
      addRow(Y, N, N, 5'd0,  32'h0,        4'hF, CI, N,   N, N, 32'h0,         N, 5'd2, SB, Y);
      addRow(Y, N, N, 5'd0,  32'h0,        4'hF, CI, N,   N, N, 32'h0,         N, 5'd2, SB, Y);
      addRow(Y, Y, N, 5'd0,  32'h0,        4'hF, CE, N,   Y, N, 32'd3,         N, 5'd3, SI, Y);
      addRow(N, N, N, 5'd0,  32'h0,        4'h0, CC, N,   N, N, 32'h0,         N, 5'd0, SI, Y);

      rstN = 1'b0;
      drive(N, N, N, 5'd0, 32'h0, 4'h0, CC, N);
      #12;
      checkOutput("reset.ack", 32'(ack), 32'(0));
      checkOutput("reset.err", 32'(err), 32'(0));
      checkOutput("reset.data", rdata, 32'h0);
      checkOutput("reset.tag", 32'(tagOut), 32'(0));
      checkOutput("reset.counter", 32'(counter), 32'(0));
      checkOutput("reset.state", 32'(state), 32'(SI));
      rstN = 1'b1;
      tick();

      foreach (vectors[i]) begin
         applyStimulus(vectors[i]);
         tick();
         checkRow(i, vectors[i]);
      end

      // Burst write from 22 runs off the end of memory on its third beat.
      drive(Y, Y, Y, 5'd22, 32'hA1, 4'hF, CI, N);
      tick();
      checkOutput("ovr.beat22.ack", 32'(ack), 32'(1));
      checkOutput("ovr.beat22.state", 32'(state), 32'(SB));
      drive(Y, Y, Y, 5'd0, 32'hA2, 4'hF, CI, N);
      tick();
      checkOutput("ovr.beat23.ack", 32'(ack), 32'(1));
      checkOutput("ovr.beat23.counter", 32'(counter), 32'(2));
      drive(Y, Y, Y, 5'd0, 32'hA3, 4'hF, CI, N);
      tick();
      checkOutput("ovr.beat24.ack", 32'(ack), 32'(0));
      checkOutput("ovr.beat24.err", 32'(err), 32'(1));
      checkOutput("ovr.beat24.state", 32'(state), 32'(SI));
      checkOutput("ovr.beat24.counter", 32'(counter), 32'(2));
      drive(N, N, N, 5'd0, 32'h0, 4'h0, CC, N);
      tick();
      checkOutput("ovr.after.err", 32'(err), 32'(0));
      classicRead("ovr.rd22", 5'd22, 32'hA1, N);
      classicRead("ovr.rd23", 5'd23, 32'hA2, N);

      // Beat counter saturates at all-ones within one long bus cycle.
      for (int i = 0; i < 33; i++) begin
         drive(Y, Y, N, 5'd0, 32'h0, 4'hF, CC, N);
         tick();
         if (i == 29) checkOutput("sat.count30", 32'(counter), 32'(30));
         drive(Y, N, N, 5'd0, 32'h0, 4'hF, CC, N);
         tick();
      end
      checkOutput("sat.count31", 32'(counter), 32'(31));
      drive(N, N, N, 5'd0, 32'h0, 4'h0, CC, N);
      tick();
      checkOutput("sat.cleared", 32'(counter), 32'(0));

      // Reset dropped in the middle of a burst read.
      drive(Y, Y, N, 5'd8, 32'h0, 4'hF, CI, N);
      tick();
      drive(Y, Y, N, 5'd0, 32'h0, 4'hF, CI, N);
      tick();
      checkOutput("rst.pre.data", rdata, 32'd2);
      rstN = 1'b0;
      #1;
      checkOutput("rst.mid.ack", 32'(ack), 32'(0));
      checkOutput("rst.mid.data", rdata, 32'h0);
      checkOutput("rst.mid.state", 32'(state), 32'(SI));
      checkOutput("rst.mid.counter", 32'(counter), 32'(0));
      drive(N, N, N, 5'd0, 32'h0, 4'h0, CC, N);
      tick();
      tick();
      rstN = 1'b1;
      tick();
      classicRead("rst.rd3", 5'd3, 32'h0, N);
      classicRead("rst.rd5", 5'd5, 32'h0, N);
      classicRead("rst.rd8", 5'd8, 32'h0, N);
      classicRead("rst.rd9", 5'd9, 32'h0, N);
      classicRead("rst.rd22", 5'd22, 32'h0, N);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
